// File: rtl/life_pkg.sv
// Shared definitions for the life-board datapath: screen limits, colour width,
// the plotter state encoding and a small width helper.
package life_pkg;

  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;
  localparam int COLOUR_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLOT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a counter over n positions; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_plotter_if.sv
// Control-to-plotter bus: coordinate/draw strobes in, VGA pixel writes and stop out.
interface cell_plotter_if;
  import life_pkg::*;

  logic                ld_x;
  logic                ld_y;
  logic                draw;
  logic [7:0]          load_val;
  logic [COLOUR_W-1:0] colour_in;
  logic [7:0]          x_out;
  logic [6:0]          y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;
  logic                stop;

  modport master (
    output ld_x, ld_y, draw, load_val, colour_in,
    input  x_out, y_out, colour_out, plot, stop
  );

  modport slave (
    input  ld_x, ld_y, draw, load_val, colour_in,
    output x_out, y_out, colour_out, plot, stop
  );

endinterface

// File: rtl/cell_plotter_square_counter.sv
// Column/row walker over a CELL_SIZE x CELL_SIZE square, column-major within a row,
// flagging the final pixel.
module square_counter
  import life_pkg::*;
#(
  parameter  int CELL_SIZE = 4,
  localparam int CW        = idx_width(CELL_SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(CELL_SIZE - 1);

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_enable) begin
      if (r_col == LAST_IDX) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_col == LAST_IDX) && (r_row == LAST_IDX);

endmodule

// File: rtl/cell_plotter.sv
// Cell plotter: latches a cell coordinate, then sweeps its pixel square one VGA
// write per cycle and raises stop once the square is finished.
module cell_plotter
  import life_pkg::*;
#(
  parameter int CELL_SIZE = 4,
  parameter int X_MAX     = SCREEN_X_MAX,
  parameter int Y_MAX     = SCREEN_Y_MAX
) (
  input  logic           clock,
  input  logic           reset,
  cell_plotter_if.slave  bus
);

  localparam int CW = idx_width(CELL_SIZE);

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_x_base;
  logic [6:0]          r_y_base;
  logic [COLOUR_W-1:0] r_colour;
  logic [7:0]          r_x_out;
  logic [6:0]          r_y_out;
  logic [COLOUR_W-1:0] r_colour_out;
  logic                r_plot;
  logic                r_stop;

  logic                w_clear;
  logic                w_enable;
  logic                w_capture;
  logic [CW-1:0]       w_col;
  logic [CW-1:0]       w_row;
  logic                w_last;
  logic [8:0]          w_px;
  logic [8:0]          w_py;
  logic                w_on_screen;
  logic [7:0]          w_x_clamped;
  logic [6:0]          w_y_clamped;

  square_counter #(.CELL_SIZE(CELL_SIZE)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_col    (w_col),
    .o_row    (w_row),
    .o_last   (w_last)
  );

  // Nine-bit sums so a square hanging off the right/bottom edge never wraps on-screen.
  assign w_px        = 9'(r_x_base) + 9'(w_col);
  assign w_py        = 9'(r_y_base) + 9'(w_row);
  assign w_on_screen = (w_px <= 9'(X_MAX)) && (w_py <= 9'(Y_MAX));

  assign w_x_clamped = (bus.load_val > 8'(X_MAX)) ? 8'(X_MAX) : bus.load_val;
  assign w_y_clamped = (bus.load_val > 8'(Y_MAX)) ? 7'(Y_MAX) : bus.load_val[6:0];

  // NOTE: every always_comb output gets a default first, so no branch infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_enable     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_capture = 1'b1;
        if (bus.draw) begin
          w_state_next = ST_PLOT;
          w_clear      = 1'b1;
        end
      end
      ST_PLOT: begin
        w_enable = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_capture = 1'b1;
        if (!bus.draw) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous and clears every register; there are no memories here.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_x_base <= '0;
      r_y_base <= '0;
      r_colour <= '0;
    end else begin
      if (w_capture && bus.ld_x) r_x_base <= w_x_clamped;
      if (w_capture && bus.ld_y) r_y_base <= w_y_clamped;
      if (w_clear)               r_colour <= bus.colour_in;
    end
  end

  // Outputs lag the counter by one edge; stop follows the DONE state by one edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_colour_out <= '0;
      r_plot       <= 1'b0;
      r_stop       <= 1'b0;
    end else begin
      r_plot <= (r_state == ST_PLOT) && w_on_screen;
      r_stop <= (r_state == ST_DONE);
      if (r_state == ST_PLOT) begin
        r_x_out      <= w_px[7:0];
        r_y_out      <= w_py[6:0];
        r_colour_out <= r_colour;
      end
    end
  end

  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.colour_out = r_colour_out;
  assign bus.plot       = r_plot;
  assign bus.stop       = r_stop;

endmodule

// File: tb/tb_cell_plotter.sv
// Scoreboard bench for cell_plotter: stimulus queues expected pixel writes, a
// negedge monitor pops and compares each plot pulse.
module tb_cell_plotter;
  import life_pkg::*;

  localparam int CS = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cell_plotter_if bus ();

  cell_plotter #(.CELL_SIZE(CS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: every plot pulse must match the head of the expected queue.
  always @(negedge clock) begin
    pix_t e;
    if (bus.plot !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 32'(bus.plot), 0);
      end else begin
        e = exp_q.pop_front();
        check("pix_x", 32'(bus.x_out), 32'(e.x));
        check("pix_y", 32'(bus.y_out), 32'(e.y));
        check("pix_colour", 32'(bus.colour_out), 32'(e.c));
      end
    end
  end

  // Expected on-screen pixels of the first npix sweep positions of a square.
  task automatic push_square(input int x, input int y, input logic [COLOUR_W-1:0] c,
                             input int npix);
    for (int i = 0; i < npix; i++) begin
      int px;
      int py;
      px = x + i % CS;
      py = y + i / CS;
      if (px <= 159 && py <= 119) exp_q.push_back({8'(px), 7'(py), c});
    end
  endtask

  task automatic load_xy(input int x, input int y);
    @(negedge clock);
    bus.ld_x = 1'b1; bus.load_val = 8'(x);
    @(negedge clock);
    bus.ld_x = 1'b0; bus.ld_y = 1'b1; bus.load_val = 8'(y);
    @(negedge clock);
    bus.ld_y = 1'b0;
  endtask

  // Holds draw from a negedge; edge k=1 samples it, so stop must appear after k=18.
  task automatic sweep(input logic [COLOUR_W-1:0] c, input int drop_k, input int ldx_k);
    int stop_k;
    stop_k = 0;
    bus.colour_in = c;
    bus.draw      = 1'b1;
    for (int k = 1; k <= 40 && stop_k == 0; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus.stop === 1'b1) stop_k = k;
      if (k == 3) bus.colour_in = ~c;
      if (k == drop_k) bus.draw = 1'b0;
      if (k == ldx_k) begin
        bus.ld_x = 1'b1; bus.load_val = 8'd50;
      end else begin
        bus.ld_x = 1'b0;
      end
    end
    check("stop_cycle", 32'(stop_k), 18);
    check("queue_drained", 32'(exp_q.size()), 0);
    if (drop_k > 0) begin
      @(posedge clock);
      @(negedge clock);
      check("stop_one_cycle", 32'(bus.stop), 0);
    end
    bus.draw = 1'b0;
    repeat (2) begin
      @(posedge clock);
      @(negedge clock);
    end
    check("stop_low_idle", 32'(bus.stop), 0);
    check("plot_low_idle", 32'(bus.plot), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ld_x = 1'b0; bus.ld_y = 1'b0; bus.draw = 1'b0;
    bus.load_val = '0; bus.colour_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_plot", 32'(bus.plot), 0);
    check("rst_stop", 32'(bus.stop), 0);
    check("rst_x", 32'(bus.x_out), 0);
    check("rst_y", 32'(bus.y_out), 0);
    check("rst_colour", 32'(bus.colour_out), 0);
    reset = 1'b1;

    // Basic 4x4 square, row by row.
    load_xy(10, 20);
    push_square(10, 20, 3'b101, 16);
    sweep(3'b101, 0, 0);

    // Bottom-right corner: only four pixels on screen, sweep length unchanged.
    load_xy(158, 118);
    push_square(158, 118, 3'b011, 16);
    sweep(3'b011, 0, 0);

    // Clamped coordinates: 200 -> 159, 130 -> 119, single visible pixel.
    load_xy(200, 130);
    exp_q.push_back({8'd159, 7'd119, 3'b110});
    sweep(3'b110, 0, 0);

    // ld_x during the sweep is ignored, and the base survives it.
    load_xy(30, 40);
    push_square(30, 40, 3'b001, 16);
    sweep(3'b001, 0, 5);
    push_square(30, 40, 3'b010, 16);
    sweep(3'b010, 0, 0);

    // Reset after the fifth pixel aborts the sweep and clears everything.
    load_xy(10, 20);
    push_square(10, 20, 3'b111, 5);
    bus.colour_in = 3'b111;
    bus.draw      = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    bus.draw = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_plot", 32'(bus.plot), 0);
    check("abort_stop", 32'(bus.stop), 0);
    check("abort_x", 32'(bus.x_out), 0);
    check("abort_y", 32'(bus.y_out), 0);
    check("abort_colour", 32'(bus.colour_out), 0);
    check("abort_pixels_seen", 32'(exp_q.size()), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push_square(0, 0, 3'b010, 16);
    sweep(3'b010, 0, 0);

    // draw dropped at pixel 3: the square still completes, stop pulses once.
    load_xy(50, 60);
    push_square(50, 60, 3'b100, 16);
    sweep(3'b100, 4, 0);

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
